// File: rtl/spmv_row_dot.sv
`timescale 1ns/1ps
// spmv_row_dot: multi-lane signed fixed-point row dot-product engine.
// Reads a row length from TIMES, accumulates LANES A*B products per joined
// A/B beat through a 3-stage pipeline (products, lane sum, accumulate), then
// pushes {overflow, sum} into a first-word fall-through output FIFO.
// Ports:
//   clk, rst              - rising-edge clock, synchronous active-high reset
//   S_AXIS_A_*/S_AXIS_B_* - LANES*DATA_W element streams, lane i at [i*DATA_W +: DATA_W]
//   S_AXIS_TIMES_*        - 32-bit unsigned row length in elements
//   M_AXIS_OUT_*          - ACC_W row sum, tuser = overflow seen in the row
module spmv_row_dot #(
    parameter int unsigned LANES      = 4,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ACC_W      = 96,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned SATURATE   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [LANES*DATA_W-1:0]   S_AXIS_A_tdata,
    input  logic                      S_AXIS_A_tvalid,
    output logic                      S_AXIS_A_tready,
    input  logic [LANES*DATA_W-1:0]   S_AXIS_B_tdata,
    input  logic                      S_AXIS_B_tvalid,
    output logic                      S_AXIS_B_tready,
    input  logic [31:0]               S_AXIS_TIMES_tdata,
    input  logic                      S_AXIS_TIMES_tvalid,
    output logic                      S_AXIS_TIMES_tready,
    output logic [ACC_W-1:0]          M_AXIS_OUT_tdata,
    output logic                      M_AXIS_OUT_tuser,
    output logic                      M_AXIS_OUT_tvalid,
    input  logic                      M_AXIS_OUT_tready
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned SUM_W  = PROD_W + $clog2(LANES);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned OCC_W  = CNT_W + 1;
    localparam int unsigned ENT_W  = ACC_W + 1;
    localparam bit          SAT    = (SATURATE != 0);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACC, FLUSH, WRITE} state_e;

    state_e                    state_q, state_d;
    logic [31:0]               rem_q, rem_d;
    logic [1:0]                flush_cnt_q, flush_cnt_d;
    logic                      ab_tready_q, ab_tready_d;
    logic                      times_tready_q, times_tready_d;

    logic signed [PROD_W-1:0]  prod_q [LANES];
    logic signed [PROD_W-1:0]  prod_d [LANES];
    logic                      p1_vld_q;
    logic signed [SUM_W-1:0]   sum_q, sum_d;
    logic                      p2_vld_q;
    logic signed [ACC_W-1:0]   acc_q, acc_d, acc_ext, acc_sum;
    logic                      ovf_q, ovf_d, add_ovf;

    logic [ENT_W-1:0]          mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [OCC_W-1:0]          occ;
    logic [ENT_W-1:0]          out_q, out_d, push_data;
    logic                      out_vld_q;

    logic                      times_fire, beat_fire, push_c, pop_c;

    assign times_fire = times_tready_q & S_AXIS_TIMES_tvalid;
    assign beat_fire  = ab_tready_q & S_AXIS_A_tvalid & S_AXIS_B_tvalid;
    assign push_c     = (state_q == WRITE);
    assign pop_c      = out_vld_q & M_AXIS_OUT_tready;
    assign push_data  = {ovf_q, acc_q};

    assign S_AXIS_A_tready     = ab_tready_q;
    assign S_AXIS_B_tready     = ab_tready_q;
    assign S_AXIS_TIMES_tready = times_tready_q;
    assign M_AXIS_OUT_tvalid   = out_vld_q;
    assign M_AXIS_OUT_tuser    = out_q[ENT_W-1];
    assign M_AXIS_OUT_tdata    = out_q[ACC_W-1:0];

    // Row sequencing: length load, beat counting, fixed drain, result push.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        flush_cnt_d = flush_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (times_fire) begin
                    rem_d   = S_AXIS_TIMES_tdata;
                    state_d = (S_AXIS_TIMES_tdata != '0) ? ACC : FLUSH;
                end
            end
            ACC: begin
                if (beat_fire) begin
                    rem_d = (rem_q > 32'(LANES)) ? rem_q - 32'(LANES) : '0;
                    if (rem_q <= 32'(LANES)) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                // Three cycles let the last beat clear P1..P3.
                if (flush_cnt_q == 2'd2) begin
                    flush_cnt_d = '0;
                    state_d     = WRITE;
                end else begin
                    flush_cnt_d = flush_cnt_q + 2'd1;
                end
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered readies; the pending push counts against space, a same-cycle pop does not.
    always_comb begin
        ab_tready_d    = (state_d == ACC);
        occ            = OCC_W'(cnt_q) + OCC_W'(push_c);
        times_tready_d = (state_d == IDLE) && (occ < OCC_W'(FIFO_DEPTH));
    end

    // P1 products; inactive lanes and bubbles are zero.
    always_comb begin
        for (int i = 0; i < int'(LANES); i++) begin
            logic signed [PROD_W-1:0] ax, bx;
            ax        = PROD_W'($signed(S_AXIS_A_tdata[i*DATA_W +: DATA_W]));
            bx        = PROD_W'($signed(S_AXIS_B_tdata[i*DATA_W +: DATA_W]));
            prod_d[i] = '0;
            if (beat_fire && (32'(i) < rem_q)) begin
                prod_d[i] = ax * bx;
            end
        end
    end

    // P2 sign-extended lane sum.
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            sum_d = sum_d + SUM_W'(prod_q[i]);
        end
    end

    // P3 accumulate with signed overflow detection; a saturated row stays clamped.
    always_comb begin
        acc_ext = ACC_W'(sum_q);
        acc_sum = acc_q + acc_ext;
        add_ovf = (acc_q[ACC_W-1] == acc_ext[ACC_W-1]) && (acc_sum[ACC_W-1] != acc_q[ACC_W-1]);
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        if (times_fire) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (p2_vld_q && !(SAT && ovf_q)) begin
            acc_d = acc_sum;
            if (add_ovf) begin
                ovf_d = 1'b1;
                if (SAT) begin
                    acc_d = acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX;
                end
            end
        end
    end

    // FWFT FIFO with a registered head: next head is looked up after this cycle's pop/push.
    always_comb begin
        cnt_d    = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
        wr_ptr_d = wr_ptr_q + PTR_W'(push_c);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);
        if (cnt_d == '0) begin
            out_d = '0;
        end else if (push_c && (wr_ptr_q == rd_ptr_d)) begin
            out_d = push_data;
        end else begin
            out_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            rem_q          <= '0;
            flush_cnt_q    <= '0;
            ab_tready_q    <= 1'b0;
            times_tready_q <= 1'b0;
            for (int i = 0; i < int'(LANES); i++) begin
                prod_q[i] <= '0;
            end
            p1_vld_q       <= 1'b0;
            sum_q          <= '0;
            p2_vld_q       <= 1'b0;
            acc_q          <= '0;
            ovf_q          <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            cnt_q          <= '0;
            out_q          <= '0;
            out_vld_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            rem_q          <= rem_d;
            flush_cnt_q    <= flush_cnt_d;
            ab_tready_q    <= ab_tready_d;
            times_tready_q <= times_tready_d;
            prod_q         <= prod_d;
            p1_vld_q       <= beat_fire;
            sum_q          <= sum_d;
            p2_vld_q       <= p1_vld_q;
            acc_q          <= acc_d;
            ovf_q          <= ovf_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            cnt_q          <= cnt_d;
            out_q          <= out_d;
            out_vld_q      <= (cnt_d != '0);
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: tb/tb_spmv_row_dot.sv
`timescale 1ns/1ps
// Bench for spmv_row_dot: directed and randomised rows, saturating and
// wrapping instances side by side, results checked from a scoreboard queue.
module tb_spmv_row_dot;

    localparam int unsigned LANES  = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ACC_W  = 2 * DATA_W + 3;
    localparam int unsigned DEPTH  = 2;
    localparam int unsigned VEC_W  = LANES * DATA_W;
    localparam longint AMAX = (longint'(1) <<< (ACC_W - 1)) - 1;
    localparam longint AMIN = -(longint'(1) <<< (ACC_W - 1));

    logic             clk, rst;
    logic [VEC_W-1:0] a_tdata, b_tdata;
    logic             a_tvalid, b_tvalid, t_tvalid, m_tready;
    logic [31:0]      t_tdata;
    logic             s_a_rdy, s_b_rdy, s_t_rdy, s_valid, s_user;
    logic             w_a_rdy, w_b_rdy, w_t_rdy, w_valid, w_user;
    logic [ACC_W-1:0] s_data, w_data;

    spmv_row_dot #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W), .FIFO_DEPTH(DEPTH), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst),
        .S_AXIS_A_tdata(a_tdata), .S_AXIS_A_tvalid(a_tvalid), .S_AXIS_A_tready(s_a_rdy),
        .S_AXIS_B_tdata(b_tdata), .S_AXIS_B_tvalid(b_tvalid), .S_AXIS_B_tready(s_b_rdy),
        .S_AXIS_TIMES_tdata(t_tdata), .S_AXIS_TIMES_tvalid(t_tvalid), .S_AXIS_TIMES_tready(s_t_rdy),
        .M_AXIS_OUT_tdata(s_data), .M_AXIS_OUT_tuser(s_user), .M_AXIS_OUT_tvalid(s_valid),
        .M_AXIS_OUT_tready(m_tready)
    );

    spmv_row_dot #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W), .FIFO_DEPTH(DEPTH), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst),
        .S_AXIS_A_tdata(a_tdata), .S_AXIS_A_tvalid(a_tvalid), .S_AXIS_A_tready(w_a_rdy),
        .S_AXIS_B_tdata(b_tdata), .S_AXIS_B_tvalid(b_tvalid), .S_AXIS_B_tready(w_b_rdy),
        .S_AXIS_TIMES_tdata(t_tdata), .S_AXIS_TIMES_tvalid(t_tvalid), .S_AXIS_TIMES_tready(w_t_rdy),
        .M_AXIS_OUT_tdata(w_data), .M_AXIS_OUT_tuser(w_user), .M_AXIS_OUT_tvalid(w_valid),
        .M_AXIS_OUT_tready(m_tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic             user;
        logic [ACC_W-1:0] data;
    } exp_t;

    exp_t   q_s[$], q_w[$];
    exp_t   es, ew;
    int     checks = 0, failures = 0, hs_cnt = 0;
    longint m_acc_s, m_acc_w;
    bit     m_ov_s, m_ov_w;
    int     m_rem;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic logic [VEC_W-1:0] pk(input int x0, input int x1, input int x2, input int x3);
        return {DATA_W'(x3), DATA_W'(x2), DATA_W'(x1), DATA_W'(x0)};
    endfunction

    function automatic void model_push();
        q_s.push_back('{user: m_ov_s, data: ACC_W'(m_acc_s)});
        q_w.push_back('{user: m_ov_w, data: ACC_W'(m_acc_w)});
    endfunction

    function automatic void model_times(input int len);
        m_rem   = len;
        m_acc_s = 0;
        m_acc_w = 0;
        m_ov_s  = 1'b0;
        m_ov_w  = 1'b0;
        if (len == 0) model_push();
    endfunction

    function automatic void model_beat(input logic [VEC_W-1:0] av, input logic [VEC_W-1:0] bv);
        longint           sum = 0;
        longint           t;
        logic [ACC_W-1:0] tw;
        for (int i = 0; i < int'(LANES); i++) begin
            if (i < m_rem)
                sum += longint'($signed(av[i*DATA_W +: DATA_W])) * longint'($signed(bv[i*DATA_W +: DATA_W]));
        end
        if (!m_ov_s) begin
            t = m_acc_s + sum;
            if (t > AMAX) begin m_acc_s = AMAX; m_ov_s = 1'b1; end
            else if (t < AMIN) begin m_acc_s = AMIN; m_ov_s = 1'b1; end
            else m_acc_s = t;
        end
        t = m_acc_w + sum;
        if (t > AMAX || t < AMIN) m_ov_w = 1'b1;
        tw      = ACC_W'(t);
        m_acc_w = longint'($signed(tw));
        m_rem   = (m_rem > int'(LANES)) ? m_rem - int'(LANES) : 0;
        if (m_rem == 0) model_push();
    endfunction

    // Presents a row length until accepted; called and returns at posedge+1.
    task automatic send_times(input int len);
        bit ok = 1'b0;
        t_tdata  = 32'(len);
        t_tvalid = 1'b1;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (s_t_rdy) ok = 1'b1;
            @(posedge clk); #1;
        end
        t_tvalid = 1'b0;
        chk("times_hs", 64'(ok), 1);
        if (ok) model_times(len);
    endtask

    // Presents one A/B beat, each stream raising valid after its own lag.
    task automatic send_beat(input logic [VEC_W-1:0] av, input logic [VEC_W-1:0] bv,
                             input int lag_a, input int lag_b);
        bit ok = 1'b0;
        a_tdata = av;
        b_tdata = bv;
        for (int c = 0; c < 200 && !ok; c++) begin
            a_tvalid = (c >= lag_a);
            b_tvalid = (c >= lag_b);
            @(negedge clk);
            if (s_a_rdy && a_tvalid && b_tvalid) ok = 1'b1;
            @(posedge clk); #1;
        end
        a_tvalid = 1'b0;
        b_tvalid = 1'b0;
        chk("beat_hs", 64'(ok), 1);
        if (ok) model_beat(av, bv);
    endtask

    // Counts A/B handshakes that the next rising edge will complete.
    always @(negedge clk) begin
        if (!rst && s_a_rdy && a_tvalid && b_tvalid) hs_cnt++;
    end

    // Output scoreboard for both instances.
    always @(negedge clk) begin
        if (!rst && s_valid && m_tready) begin
            chk("sat_expected", 64'(q_s.size() != 0), 1);
            if (q_s.size() != 0) begin
                es = q_s.pop_front();
                chk("sat_data", 64'(s_data), 64'(es.data));
                chk("sat_user", 64'(s_user), 64'(es.user));
            end
        end
        if (!rst && w_valid && m_tready) begin
            chk("wrap_expected", 64'(q_w.size() != 0), 1);
            if (q_w.size() != 0) begin
                ew = q_w.pop_front();
                chk("wrap_data", 64'(w_data), 64'(ew.data));
                chk("wrap_user", 64'(w_user), 64'(ew.user));
            end
        end
    end

    initial begin
        int hs0, rdy_hi, vld_hi, len, nb, lag;
        logic [VEC_W-1:0] av, bv;

        rst = 1'b1; a_tvalid = 1'b0; b_tvalid = 1'b0; t_tvalid = 1'b0; m_tready = 1'b1;
        a_tdata = '0; b_tdata = '0; t_tdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_t_rdy", 64'(s_t_rdy), 0);
        chk("rst_a_rdy", 64'(s_a_rdy), 0);
        chk("rst_valid", 64'(s_valid), 0);
        chk("rst_data",  64'(s_data), 0);
        chk("rst_user",  64'(s_user), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_t_rdy", 64'(s_t_rdy), 1);
        chk("post_rst_a_rdy", 64'(s_a_rdy), 0);

        // Single full beat, with output latency.
        send_times(4);
        send_beat(pk(1, 2, 3, 4), pk(5, 6, 7, 8), 0, 0);
        repeat (3) @(posedge clk); #1;
        chk("lat_beat_k3", 64'(s_valid), 0);
        @(posedge clk); #1;
        chk("lat_beat_k4", 64'(s_valid), 1);
        repeat (3) @(posedge clk); #1;

        // Partial last beat, with lanes 2/3 masked; extra valids must not be taken.
        hs0 = hs_cnt;
        send_times(6);
        send_beat(pk(1, 1, 1, 1), pk(1, 1, 1, 1), 0, 0);
        send_beat(pk(2, 2, 9, 9), pk(1, 1, 1, 1), 0, 0);
        a_tdata = pk(50, 50, 50, 50); b_tdata = pk(50, 50, 50, 50);
        a_tvalid = 1'b1; b_tvalid = 1'b1;
        repeat (10) @(posedge clk); #1;
        chk("row6_beats", 64'(hs_cnt - hs0), 2);

        // Zero-length row with A/B valid held high.
        hs0 = hs_cnt;
        send_times(0);
        repeat (3) @(posedge clk); #1;
        chk("lat_len0_k3", 64'(s_valid), 0);
        @(posedge clk); #1;
        chk("lat_len0_k4", 64'(s_valid), 1);
        a_tvalid = 1'b0; b_tvalid = 1'b0;
        chk("len0_beats", 64'(hs_cnt - hs0), 0);

        // Overflow: four beats of the largest product, then a clean row.
        send_times(16);
        for (int i = 0; i < 4; i++)
            send_beat(pk(-128, -128, -128, -128), pk(-128, -128, -128, -128), 0, 0);
        send_times(4);
        send_beat(pk(1, 1, 1, 1), pk(1, 1, 1, 1), 0, 0);
        repeat (8) @(posedge clk); #1;

        // FIFO full blocks TIMES until results are popped.
        m_tready = 1'b0;
        send_times(1);
        send_beat(pk(5, 0, 0, 0), pk(5, 0, 0, 0), 0, 0);
        send_times(1);
        send_beat(pk(7, 0, 0, 0), pk(3, 0, 0, 0), 0, 0);
        t_tdata = 32'd4; t_tvalid = 1'b1;
        repeat (6) @(posedge clk); #1;
        rdy_hi = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (s_t_rdy) rdy_hi++;
        end
        chk("full_t_rdy", 64'(rdy_hi), 0);
        chk("hold_valid", 64'(s_valid), 1);
        chk("hold_data", 64'(s_data), 25);
        @(posedge clk); #1;
        m_tready = 1'b1;
        send_times(4);
        send_beat(pk(1, 2, 3, 4), pk(1, 1, 1, 1), 0, 0);
        repeat (8) @(posedge clk); #1;

        // Random rows with gaps and one stream lagging the other.
        for (int r = 0; r < 8; r++) begin
            len = int'($urandom_range(0, 13));
            send_times(len);
            nb = (len + 3) / 4;
            for (int b = 0; b < nb; b++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                av  = $urandom;
                bv  = $urandom;
                lag = int'($urandom_range(0, 3));
                if ($urandom_range(0, 1) == 1) send_beat(av, bv, lag, 0);
                else send_beat(av, bv, 0, lag);
            end
        end

        for (int c = 0; c < 100 && (q_s.size() != 0 || q_w.size() != 0); c++) @(posedge clk);
        #1;
        chk("pre_rst_drain", 64'(q_s.size() + q_w.size()), 0);

        // Reset in the middle of a row discards it.
        send_times(12);
        send_beat(pk(9, 9, 9, 9), pk(9, 9, 9, 9), 0, 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_a_rdy", 64'(s_a_rdy), 0);
        chk("midrst_t_rdy", 64'(s_t_rdy), 0);
        chk("midrst_valid", 64'(s_valid), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        vld_hi = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (s_valid || w_valid) vld_hi++;
        end
        chk("aborted_row_out", 64'(vld_hi), 0);
        @(posedge clk); #1;
        send_times(5);
        send_beat(pk(1, 2, 3, 4), pk(2, 2, 2, 2), 2, 0);
        send_beat(pk(5, 9, 9, 9), pk(3, 1, 1, 1), 0, 3);

        for (int c = 0; c < 100 && (q_s.size() != 0 || q_w.size() != 0); c++) @(posedge clk);
        #1;
        chk("final_drain", 64'(q_s.size() + q_w.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
